// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU subsystem: command FSM states, frame headers
// and the ALU function codes understood by the parametrized ALU.
package alu_sys_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_GET_FUN  = 3'd3,
    ST_ALU_FIRE = 3'd4,
    ST_ALU_WAIT = 3'd5,
    ST_TX_LO    = 3'd6,
    ST_TX_HI    = 3'd7
  } state_e;

  localparam logic [7:0] CMD_OP_HDR  = 8'hCC;
  localparam logic [7:0] CMD_NOP_HDR = 8'hDD;

  typedef enum logic [3:0] {
    FUN_ADD    = 4'd0,
    FUN_SUB    = 4'd1,
    FUN_MUL    = 4'd2,
    FUN_DIV    = 4'd3,
    FUN_AND    = 4'd4,
    FUN_OR     = 4'd5,
    FUN_NAND   = 4'd6,
    FUN_NOR    = 4'd7,
    FUN_XOR    = 4'd8,
    FUN_XNOR   = 4'd9,
    FUN_CMP_EQ = 4'd10,
    FUN_CMP_GT = 4'd11,
    FUN_CMP_LT = 4'd12,
    FUN_SHR    = 4'd13,
    FUN_SHL    = 4'd14
  } alu_fun_e;

endpackage

// File: rtl/alu_cmd_watchdog.sv
// Loadable up-counter that flags expiry once it reaches TIMEOUT-1.
module alu_cmd_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the ALU: parses serial frames, fires the ALU, and
// returns the result low byte then high byte over a valid/ready handshake.
module alu_cmd_ctrl
  import alu_sys_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            OUT_WIDTH   = 2 * DATA_WIDTH,
  parameter int unsigned            TIMEOUT     = 16,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_OP  = CMD_OP_HDR,
  parameter logic [DATA_WIDTH-1:0]  CMD_ALU_NOP = CMD_NOP_HDR
) (
  input  logic                  REF_CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  CMD_ERR,
  output logic                  OVR_ERR,
  output logic                  TO_ERR
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  alu_en_q, alu_en_d;
  logic [OUT_WIDTH-1:0]  result_q, result_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  ovr_err_q, ovr_err_d;
  logic                  to_err_q, to_err_d;
  logic                  wd_load, wd_inc, wd_expired;

  alu_cmd_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (REF_CLK),
    .rst_n   (RST),
    .load    (wd_load),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Outputs are computed from the next state so they line up with it once registered.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    alu_en_d  = 1'b0;
    result_d  = result_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;
    ovr_err_d = 1'b0;
    to_err_d  = 1'b0;
    wd_load   = 1'b0;
    wd_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_ALU_OP) begin
            state_d = ST_GET_A;
          end else if (RX_P_DATA == CMD_ALU_NOP) begin
            state_d = ST_GET_FUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_GET_A: begin
        if (RX_D_VLD) begin
          alu_a_d = RX_P_DATA;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (RX_D_VLD) begin
          alu_b_d = RX_P_DATA;
          state_d = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_FIRE;
        end
      end
      ST_ALU_FIRE: begin
        wd_load = 1'b1;
        state_d = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: begin
        wd_inc = 1'b1;
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (ALU_OUT_VLD) begin
          result_d  = ALU_OUT;
          tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = ST_TX_LO;
        end else if (wd_expired) begin
          to_err_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_TX_LO: begin
        tx_vld_d = 1'b1;
        if (TX_READY) begin
          tx_data_d = result_q[OUT_WIDTH-1:DATA_WIDTH];
          state_d   = ST_TX_HI;
        end else begin
          tx_data_d = result_q[DATA_WIDTH-1:0];
        end
      end
      ST_TX_HI: begin
        if (TX_READY) begin
          state_d = ST_IDLE;
        end else begin
          tx_vld_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (RX_D_VLD && (state_q inside {ST_ALU_FIRE, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI})) begin
      ovr_err_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      result_q  <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      result_q  <= result_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
      ovr_err_q <= ovr_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign ALU_EN    = alu_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign BUSY      = busy_q;
  assign CMD_ERR   = cmd_err_q;
  assign OVR_ERR   = ovr_err_q;
  assign TO_ERR    = to_err_q;

endmodule
